// File: rtl/conv5_pool.sv
// 2x2 stride-2 pooling over one 2-row bank of the conv-layer-2 ping-pong buffer.
// Max pooling by default; define CONV5_POOL_AVG_EN for floor-average pooling.
module conv5_pool #(
    parameter int DATA_W = 8,
    parameter int COLS   = 8,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        bank_full,
    output logic [1:0]        bank_release,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pool_valid,
    output logic [DATA_W-1:0] pool_data,
    input  logic              pool_ready
);

    localparam int WIN_W = (COLS > 2) ? $clog2(COLS / 2) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(COLS / 2 - 1);
`ifdef CONV5_POOL_AVG_EN
    localparam int ACC_W = DATA_W + 2;
`else
    localparam int ACC_W = DATA_W;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_RD3  = 3'd4,
        S_LAST = 3'd5,
        S_EMIT = 3'd6
    } state_t;

    state_t              state_q;
    logic                cur_bank_q;
    logic [WIN_W-1:0]    win_q;
    logic [ACC_W-1:0]    acc_q;
    logic [1:0]          bank_release_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                pool_valid_q;
    logic [DATA_W-1:0]   pool_data_q;
    logic [WIN_W-1:0]    win_d;

    // Element e of window w: row e[1], column 2w + e[0].
    function automatic logic [ADDR_W-1:0] elem_addr(input logic bank,
                                                    input logic [WIN_W-1:0] w,
                                                    input logic [1:0] e);
        logic [ADDR_W-1:0] base;
        base = bank ? ADDR_W'(2 * COLS) : {ADDR_W{1'b0}};
        if (e[1]) begin
            base = base + ADDR_W'(COLS);
        end else begin
            base = base;
        end
        return base + ADDR_W'({w, e[0]});
    endfunction

    function automatic logic [ACC_W-1:0] fold(input logic [ACC_W-1:0] a,
                                              input logic [DATA_W-1:0] d);
`ifdef CONV5_POOL_AVG_EN
        return a + ACC_W'(d);
`else
        return (d > a) ? d : a;
`endif
    endfunction

    function automatic logic [DATA_W-1:0] reduce(input logic [ACC_W-1:0] a);
`ifdef CONV5_POOL_AVG_EN
        return DATA_W'(a >> 2);
`else
        return a;
`endif
    endfunction

    // Next window index, used when the EMIT handshake moves on within a bank.
    always_comb begin
        win_d = win_q + WIN_W'(1);
    end

    // Control FSM, read sequencing, accumulation and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            cur_bank_q     <= 1'b0;
            win_q          <= {WIN_W{1'b0}};
            acc_q          <= {ACC_W{1'b0}};
            bank_release_q <= 2'b00;
            rd_en_q        <= 1'b0;
            rd_addr_q      <= {ADDR_W{1'b0}};
            pool_valid_q   <= 1'b0;
            pool_data_q    <= {DATA_W{1'b0}};
        end else begin
            bank_release_q <= 2'b00;
            case (state_q)
                S_IDLE: begin
                    if (bank_full[cur_bank_q]) begin
                        win_q     <= {WIN_W{1'b0}};
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= elem_addr(cur_bank_q, {WIN_W{1'b0}}, 2'd0);
                        state_q   <= S_RD0;
                    end
                end
                S_RD0: begin
                    rd_addr_q <= elem_addr(cur_bank_q, win_q, 2'd1);
                    state_q   <= S_RD1;
                end
                S_RD1: begin
                    acc_q     <= ACC_W'(rd_data);
                    rd_addr_q <= elem_addr(cur_bank_q, win_q, 2'd2);
                    state_q   <= S_RD2;
                end
                S_RD2: begin
                    acc_q     <= fold(acc_q, rd_data);
                    rd_addr_q <= elem_addr(cur_bank_q, win_q, 2'd3);
                    state_q   <= S_RD3;
                end
                S_RD3: begin
                    acc_q   <= fold(acc_q, rd_data);
                    rd_en_q <= 1'b0;
                    state_q <= S_LAST;
                end
                S_LAST: begin
                    // Element 3 arrives now; fold it straight into the output register.
                    pool_data_q  <= reduce(fold(acc_q, rd_data));
                    pool_valid_q <= 1'b1;
                    state_q      <= S_EMIT;
                end
                S_EMIT: begin
                    if (pool_ready) begin
                        pool_valid_q <= 1'b0;
                        if (win_q != WIN_LAST) begin
                            win_q     <= win_d;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= elem_addr(cur_bank_q, win_d, 2'd0);
                            state_q   <= S_RD0;
                        end else begin
                            bank_release_q[cur_bank_q] <= 1'b1;
                            cur_bank_q                 <= ~cur_bank_q;
                            state_q                    <= S_IDLE;
                        end
                    end
                end
                default: begin
                    rd_en_q      <= 1'b0;
                    pool_valid_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
            endcase
        end
    end

    assign bank_release = bank_release_q;
    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign pool_valid   = pool_valid_q;
    assign pool_data    = pool_data_q;

endmodule

// File: tb/tb_conv5_pool.sv
// Scoreboard bench for conv5_pool: directed banks with hand-computed pooled results.
module tb_conv5_pool;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] bank_full;
    logic [1:0] bank_release;
    logic       rd_en;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       pool_valid;
    logic [7:0] pool_data;
    logic       pool_ready;

    logic [7:0] mem [0:127];
    int         exp_q[$];
    int         rel_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

`ifdef CONV5_POOL_AVG_EN
    int exp_b0[4]  = '{4, 6, 8, 10};
    int exp_b1[4]  = '{250, 248, 246, 244};
    int exp_ord[4] = '{102, 254, 0, 0};
    int exp_bp     = 6;
`else
    int exp_b0[4]  = '{9, 11, 13, 15};
    int exp_b1[4]  = '{255, 253, 251, 249};
    int exp_ord[4] = '{200, 0, 0, 0};
    int exp_bp     = 11;
`endif

    conv5_pool dut (
        .clk          (clk),
        .rst          (rst),
        .bank_full    (bank_full),
        .bank_release (bank_release),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .pool_valid   (pool_valid),
        .pool_data    (pool_data),
        .pool_ready   (pool_ready)
    );

    always #5 clk = ~clk;

    // Buffer model with a registered read port returning 0 when idle.
    always @(posedge clk) begin
        rd_data <= rd_en ? mem[rd_addr] : 8'd0;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: pops expected results/releases whenever the DUT presents them.
    always @(negedge clk) begin
        if (rst && pool_valid && pool_ready) begin
            if (exp_q.size() == 0) chk("unexpected_output", int'(pool_data), -1);
            else chk("pool_data", int'(pool_data), exp_q.pop_front());
        end
        if (rst && bank_release != 2'b00) begin
            if (rel_q.size() == 0) chk("unexpected_release", int'(bank_release), 0);
            else chk("bank_release", int'(bank_release), rel_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bank_full  = 2'b00;
        pool_ready = 1'b1;
        rst        = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic load_std();
        for (int i = 0; i < 16; i++) mem[i] = 8'(i);
        for (int i = 16; i < 32; i++) mem[i] = 8'(255 - (i - 16));
    endtask

    task automatic push_bank(input int b);
        for (int i = 0; i < 4; i++) exp_q.push_back(b == 0 ? exp_b0[i] : exp_b1[i]);
        rel_q.push_back(b == 0 ? 1 : 2);
    endtask

    task automatic wait_release(input string nm);
        bit seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            tick();
            if (bank_release != 2'b00) seen = 1'b1;
        end
        if (!seen) chk({nm, "_release_timeout"}, 0, 1);
    endtask

    task automatic wait_valid(input string nm);
        bit seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            tick();
            if (pool_valid) seen = 1'b1;
        end
        if (!seen) chk({nm, "_valid_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        bit seen;
        for (int i = 0; i < 128; i++) mem[i] = 8'd0;
        load_std();
        do_reset();

        // Reset state
        chk("rst_bank_release", int'(bank_release), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_pool_valid", int'(pool_valid), 0);
        chk("rst_pool_data", int'(pool_data), 0);

        // Single bank, latency from IDLE sample to pool_valid
        push_bank(0);
        bank_full = 2'b01;
        cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            cnt++;
            if (pool_valid) seen = 1'b1;
        end
        chk("first_valid_latency", cnt, 6);
        wait_release("single");
        bank_full = 2'b00;
        chk("cur_bank_after_release", int'(dut.cur_bank_q), 1);
        tick();

        // Ping-pong over both banks
        do_reset();
        push_bank(0);
        push_bank(1);
        bank_full = 2'b11;
        wait_release("pp0");
        bank_full = 2'b10;
        wait_release("pp1");
        bank_full = 2'b00;
        tick();

        // Backpressure on the second window
        do_reset();
        push_bank(0);
        bank_full = 2'b01;
        wait_valid("bp_w0");
        tick();
        wait_valid("bp_w1");
        pool_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("bp_pool_valid", int'(pool_valid), 1);
            chk("bp_pool_data", int'(pool_data), exp_bp);
            chk("bp_rd_en", int'(rd_en), 0);
        end
        pool_ready = 1'b1;
        wait_release("bp");
        bank_full = 2'b00;
        tick();

        // Window ordering / reduction corner values
        do_reset();
        for (int i = 0; i < 16; i++) mem[i] = 8'd0;
        mem[0] = 8'd7;  mem[1] = 8'd200;  mem[8] = 8'd3;  mem[9] = 8'd199;
`ifdef CONV5_POOL_AVG_EN
        mem[2] = 8'd255; mem[3] = 8'd255; mem[10] = 8'd255; mem[11] = 8'd254;
`endif
        for (int i = 0; i < 4; i++) exp_q.push_back(exp_ord[i]);
        rel_q.push_back(1);
        bank_full = 2'b01;
        wait_release("ord");
        bank_full = 2'b00;
        load_std();
        tick();

        // Reset in the middle of a window
        do_reset();
        bank_full = 2'b01;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (rd_en && rd_addr == 7'd8) seen = 1'b1;
        end
        if (!seen) chk("midrst_rd2_timeout", 0, 1);
        rst = 1'b0;
        bank_full = 2'b00;
        tick();
        chk("midrst_bank_release", int'(bank_release), 0);
        chk("midrst_rd_en", int'(rd_en), 0);
        chk("midrst_rd_addr", int'(rd_addr), 0);
        chk("midrst_pool_valid", int'(pool_valid), 0);
        chk("midrst_pool_data", int'(pool_data), 0);
        chk("midrst_state_idle", int'(dut.state_q), 0);
        rst = 1'b1;
        push_bank(0);
        bank_full = 2'b01;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (rd_en) seen = 1'b1;
        end
        chk("restart_rd_seen", int'(seen), 1);
        chk("restart_rd_addr", int'(rd_addr), 0);
        wait_release("restart");
        bank_full = 2'b00;
        tick();

        // Wrong-bank fill is ignored
        do_reset();
        bank_full = 2'b10;
        cnt = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (rd_en) cnt++;
        end
        chk("wrong_bank_rd_en_cycles", cnt, 0);
        bank_full = 2'b00;
        tick();
        tick();

        chk("outputs_outstanding", exp_q.size(), 0);
        chk("releases_outstanding", rel_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv5_pool.md
# conv5_pool

2x2 stride-2 pooling stage directly downstream of the conv-layer-2 output ping-pong buffer (32 x 8-bit, two 16-entry banks of 2 rows x 8 columns). When the writer marks a bank full, this block reads the bank through the buffer's registered read port and reduces each 2x2 window to one 8-bit value. It emits 4 pooled results per bank on a valid/ready stream to the next layer, then releases the bank back to the writer. Banks are consumed strictly alternately: 0, 1, 0, ...

## Interface
Parameters:
- DATA_W, 8, pixel width; unsigned, post-ReLU
- COLS, 8, columns per bank row; must be even
- ADDR_W, 7, buffer read address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- bank_full  in  2  level from writer; bit b high = bank b holds 2 complete rows
- bank_release  out  2  one-cycle pulse; bit b = bank b consumed
- rd_en  out  1  buffer read enable
- rd_addr  out  ADDR_W  buffer read address
- rd_data  in  DATA_W  buffer read data, valid 1 cycle after rd_en
- pool_valid  out  1  pooled result valid
- pool_data  out  DATA_W  pooled result
- pool_ready  in  1  downstream accepts pool_data

## Operation
- Registers: cur_bank (1 b), win (0..COLS/2-1), acc (DATA_W), state.
- Bank b address map: b*2*COLS + r*COLS + c, with r in 0..1 and c in 0..COLS-1.
- Window w reads, in order: (r0, 2w), (r0, 2w+1), (r1, 2w), (r1, 2w+1). For bank 0, w=0 these are addr 0, 1, 8, 9.
- States:
  - IDLE: if bank_full[cur_bank], set win=0 and go to RD0; all other bank_full bits are ignored.
  - RD0..RD3: rd_en=1, rd_addr = window element 0..3. Advance one state per cycle.
  - LAST: rd_en=0; fold in element 3.
  - EMIT: pool_valid=1 and held; pool_data stable until pool_ready.
- On the EMIT handshake:
  - If win < COLS/2-1: win++ and go to RD0.
  - Otherwise: pulse bank_release[cur_bank] in the next cycle, toggle cur_bank, go to IDLE.
- Accumulate:
  - Cycle after RD0: acc <= rd_data.
  - Cycles after RD1..RD3: acc <= max(acc, rd_data), unsigned compare.
  - pool_data is registered from the final acc on entry to EMIT.
- rd_en is 0 in IDLE, LAST and EMIT. The buffer returns 0 then, and the data path ignores it.
- Reset outputs: bank_release=0, rd_en=0, rd_addr=0, pool_valid=0, pool_data=0. Internal: cur_bank=0, win=0, acc=0, state=IDLE.
- Reset mid-operation: the partial window is discarded, no release pulse is issued, and processing restarts at bank 0.

## Timing
- Entering RD0 at cycle t: reads issue at t..t+3, data returns t+1..t+4, pool_valid rises at t+5.
- Minimum 6 cycles per window with pool_ready held high; 24 cycles per bank plus 1 IDLE cycle.
- pool_ready low while pool_valid=1: state, pool_data and rd_en=0 hold indefinitely; no reads are issued.
- bank_release pulse: cycle after the final handshake. The writer must deassert bank_full[b] within that cycle. The block already points at the other bank, so a lingering level is harmless until the next visit.
- bank_full rising while in EMIT is registered only on return to IDLE.

## Configuration
- CONV5_POOL_AVG_EN defined: average pooling.
  - Uses a DATA_W+2-bit sum: first element loads, the next three add.
  - pool_data = sum >> 2, truncated (floor), no rounding.
- Undefined: max pooling as above.
- Latency, handshake and address order are identical in both modes.

## Test plan
- Single bank, max mode, no backpressure: bank 0 loaded with addr i -> i. bank_full=01 -> outputs 9, 11, 13, 15; pool_valid first rises 6 cycles after bank_full is sampled high in IDLE (IDLE cycle plus 5); bank_release=01 pulse; cur_bank=1.
- Ping-pong: bank 1 loaded with value 255 - (i-16) at addr i (addr 16 -> 255, addr 31 -> 240). Assert bank_full=11 -> 9, 11, 13, 15, then 255, 253, 251, 249; releases 01 then 10, in order.
- Backpressure: hold pool_ready=0 for 10 cycles on the second window -> pool_data stays 11, rd_en stays 0, and no output is lost or duplicated.
- Max ordering: window contents {7, 200, 3, 199} and {0, 0, 0, 0} -> 200 then 0. Under CONV5_POOL_AVG_EN, {7, 200, 3, 199} -> 102 and {255, 255, 255, 254} -> 254.
- Reset mid-window: assert rst=0 during RD2 -> next cycle all outputs 0 and state IDLE. After release, bank_full=01 restarts bank 0 window 0 at addr 0.
- Wrong-bank fill: bank_full=10 with cur_bank=0 -> no rd_en activity for 50 cycles.
